// File: rtl/proc_pkg.sv
// Shared definitions for the multi-cycle processor: opcodes, sequencer states
// and instruction field positions used by the controller, register file and ALU.
package proc_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 3;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_HALT = 3'd1;
    localparam logic [2:0] OP_BEQ  = 3'd2;
    localparam logic [2:0] OP_BLT  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_AND  = 3'd6;
    localparam logic [2:0] OP_OR   = 3'd7;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 29;
    localparam int unsigned RD_MSB  = 28;
    localparam int unsigned RD_LSB  = 26;
    localparam int unsigned RS1_MSB = 25;
    localparam int unsigned RS1_LSB = 23;
    localparam int unsigned RS2_MSB = 22;
    localparam int unsigned RS2_LSB = 20;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_BRANCH,
        S_HALT
    } state_t;

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: arithmetic/logic result plus the branch-taken decision
// (BEQ equality, BLT unsigned less-than).
module alu
    import proc_pkg::*;
(
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [2:0]      i_opcode,
    output logic [XLEN-1:0] o_result,
    output logic            o_change_pc
);

    always_comb begin
        o_result    = '0;
        o_change_pc = 1'b0;
        case (i_opcode)
            OP_ADD: o_result = i_a + i_b;
            OP_SUB: o_result = i_a - i_b;
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_BEQ: begin
                o_result    = i_a - i_b;
                o_change_pc = (i_a == i_b);
            end
            OP_BLT: begin
                o_result    = i_a - i_b;
                o_change_pc = (i_a < i_b);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/reg_file.sv
// 8x32 register file: two async operand read ports, one async debug port,
// one synchronous write port; r0 reads as zero and ignores writes.
module reg_file
    import proc_pkg::*;
#(
    parameter int unsigned NREG = 8,
    parameter int unsigned DW   = XLEN,
    parameter int unsigned AW   = REG_AW
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] i_raddr_a,
    input  logic [AW-1:0] i_raddr_b,
    input  logic [AW-1:0] i_raddr_dbg,
    output logic [DW-1:0] o_rdata_a,
    output logic [DW-1:0] o_rdata_b,
    output logic [DW-1:0] o_rdata_dbg,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata
);

    logic [DW-1:0] r_regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a   = (i_raddr_a   == '0) ? '0 : r_regs[i_raddr_a];
    assign o_rdata_b   = (i_raddr_b   == '0) ? '0 : r_regs[i_raddr_b];
    assign o_rdata_dbg = (i_raddr_dbg == '0) ? '0 : r_regs[i_raddr_dbg];

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle sequencer: fetches over a req/valid handshake, reads operands,
// drives an external ALU and writes back or redirects the PC.
module multi_cycle_ctrl
    import proc_pkg::*;
#(
    parameter int unsigned PC_W = 16,
    parameter int unsigned NREG = 8
)(
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_valid,
    output logic [31:0]     alu_ip_0,
    output logic [31:0]     alu_ip_1,
    output logic [2:0]      alu_opcode,
    input  logic [31:0]     alu_op_0,
    input  logic            alu_change_pc,
    output logic [PC_W-1:0] pc,
    output logic            retire,
    output logic            halted,
    input  logic [2:0]      dbg_raddr,
    output logic [31:0]     dbg_rdata
);

    state_t          r_state;
    state_t          w_next;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [31:0]     r_aluout;

    logic [2:0]      w_op;
    logic [2:0]      w_rd;
    logic [2:0]      w_rs1;
    logic [2:0]      w_rs2;
    logic [PC_W-1:0] w_imm_pc;
    logic [PC_W-1:0] w_pc_plus1;
    logic [PC_W-1:0] w_pc_target;
    logic [31:0]     w_rs1_data;
    logic [31:0]     w_rs2_data;

    logic            w_ir_load;
    logic            w_ab_load;
    logic            w_aluout_load;
    logic            w_rf_we;
    logic            w_pc_inc;
    logic            w_pc_branch;

    assign w_op  = r_ir[OPC_MSB:OPC_LSB];
    assign w_rd  = r_ir[RD_MSB:RD_LSB];
    assign w_rs1 = r_ir[RS1_MSB:RS1_LSB];
    assign w_rs2 = r_ir[RS2_MSB:RS2_LSB];

    // Signed size cast sign-extends or truncates the word offset to PC_W.
    assign w_imm_pc    = PC_W'($signed(r_ir[IMM_MSB:IMM_LSB]));
    assign w_pc_plus1  = r_pc + PC_W'(1);
    assign w_pc_target = w_pc_plus1 + w_imm_pc;

    logic w_unused_ir;
    assign w_unused_ir = ^r_ir[19:16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = S_WAIT;
            S_WAIT:   w_next = imem_valid ? S_DECODE : S_WAIT;
            S_DECODE: begin
                if (w_op == OP_NOP) begin
                    w_next = S_FETCH;
                end else if (w_op == OP_HALT) begin
                    w_next = S_HALT;
                end else if (is_alu_op(w_op)) begin
                    w_next = S_EXEC;
                end else begin
                    w_next = S_BRANCH;
                end
            end
            S_EXEC:   w_next = S_WB;
            S_WB:     w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        imem_req      = 1'b0;
        retire        = 1'b0;
        halted        = 1'b0;
        w_ir_load     = 1'b0;
        w_ab_load     = 1'b0;
        w_aluout_load = 1'b0;
        w_rf_we       = 1'b0;
        w_pc_inc      = 1'b0;
        w_pc_branch   = 1'b0;
        case (r_state)
            // Gated by rst_n so the request stays low while reset is held.
            S_FETCH:  imem_req = rst_n;
            S_WAIT:   w_ir_load = imem_valid;
            S_DECODE: begin
                if (w_op == OP_NOP) begin
                    w_pc_inc = 1'b1;
                    retire   = 1'b1;
                end else if (w_op == OP_HALT) begin
                    retire   = 1'b1;
                end else begin
                    w_ab_load = 1'b1;
                end
            end
            S_EXEC:   w_aluout_load = 1'b1;
            S_WB: begin
                w_rf_we  = 1'b1;
                w_pc_inc = 1'b1;
                retire   = 1'b1;
            end
            S_BRANCH: begin
                w_pc_branch = alu_change_pc;
                w_pc_inc    = ~alu_change_pc;
                retire      = 1'b1;
            end
            S_HALT:   halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
        end else begin
            if (w_ir_load) begin
                r_ir <= imem_rdata;
            end
            if (w_ab_load) begin
                r_a <= w_rs1_data;
                r_b <= w_rs2_data;
            end
            if (w_aluout_load) begin
                r_aluout <= alu_op_0;
            end
            if (w_pc_branch) begin
                r_pc <= w_pc_target;
            end else if (w_pc_inc) begin
                r_pc <= w_pc_plus1;
            end
        end
    end

    reg_file #(
        .NREG (NREG),
        .DW   (32),
        .AW   (3)
    ) u_reg_file (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_raddr_a   (w_rs1),
        .i_raddr_b   (w_rs2),
        .i_raddr_dbg (dbg_raddr),
        .o_rdata_a   (w_rs1_data),
        .o_rdata_b   (w_rs2_data),
        .o_rdata_dbg (dbg_rdata),
        .i_we        (w_rf_we),
        .i_waddr     (w_rd),
        .i_wdata     (r_aluout)
    );

    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign alu_opcode = w_op;
    assign alu_ip_0   = r_a;
    assign alu_ip_1   = r_b;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized bench for multi_cycle_ctrl: an instruction-level reference model
// predicts fetch/retire cycles, PC and register contents from the ISA rules.
module tb_multi_cycle_ctrl;

    localparam int unsigned PC_W = 16;

    localparam logic [2:0] T_NOP  = 3'd0;
    localparam logic [2:0] T_HALT = 3'd1;
    localparam logic [2:0] T_BEQ  = 3'd2;
    localparam logic [2:0] T_BLT  = 3'd3;
    localparam logic [2:0] T_ADD  = 3'd4;
    localparam logic [2:0] T_SUB  = 3'd5;
    localparam logic [2:0] T_AND  = 3'd6;
    localparam logic [2:0] T_OR   = 3'd7;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata = '0;
    logic            imem_valid = 1'b0;
    logic [31:0]     alu_ip_0;
    logic [31:0]     alu_ip_1;
    logic [2:0]      alu_opcode;
    logic [31:0]     alu_op_0;
    logic            alu_change_pc;
    logic [PC_W-1:0] pc;
    logic            retire;
    logic            halted;
    logic [2:0]      dbg_raddr = '0;
    logic [31:0]     dbg_rdata;

    logic [31:0]     w_alu_res;
    logic            ovr_en = 1'b0;
    logic [31:0]     ovr_val = '0;

    always #5 clk = ~clk;

    multi_cycle_ctrl #(.PC_W(PC_W), .NREG(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .alu_ip_0      (alu_ip_0),
        .alu_ip_1      (alu_ip_1),
        .alu_opcode    (alu_opcode),
        .alu_op_0      (alu_op_0),
        .alu_change_pc (alu_change_pc),
        .pc            (pc),
        .retire        (retire),
        .halted        (halted),
        .dbg_raddr     (dbg_raddr),
        .dbg_rdata     (dbg_rdata)
    );

    alu u_alu (
        .i_a         (alu_ip_0),
        .i_b         (alu_ip_1),
        .i_opcode    (alu_opcode),
        .o_result    (w_alu_res),
        .o_change_pc (alu_change_pc)
    );

    // Seeded instructions get their result injected so registers can be preloaded.
    assign alu_op_0 = ovr_en ? ovr_val : w_alu_res;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [31:0] mem  [int];
    logic [31:0] seed [int];
    int          lat_fix [int];

    logic [15:0] m_pc;
    logic [31:0] m_reg [8];
    bit          m_halted;
    logic [31:0] m_ir;
    int          cyc;
    int          m_req_cyc;
    int          m_ret_cyc;

    function automatic logic [31:0] enc(input logic [2:0] op, input int rd, input int rs1,
                                        input int rs2, input int imm);
        logic [31:0] w;
        w        = '0;
        w[31:29] = op;
        w[28:26] = 3'(rd);
        w[25:23] = 3'(rs1);
        w[22:20] = 3'(rs2);
        w[15:0]  = 16'(imm);
        return w;
    endfunction

    function automatic logic [31:0] fetch_word(input int a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Cycles from the request cycle to retire beyond the memory latency.
    function automatic int ret_offset(input logic [2:0] op);
        if (op == T_NOP || op == T_HALT) return 1;
        if (op == T_BEQ || op == T_BLT) return 2;
        return 3;
    endfunction

    task automatic model_init();
        m_pc      = '0;
        m_halted  = 1'b0;
        m_ir      = '0;
        cyc       = 0;
        m_req_cyc = 0;
        m_ret_cyc = -1;
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
    endtask

    task automatic model_retire(input int addr);
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [15:0] nxt;
        int          rd;
        op  = m_ir[31:29];
        rd  = int'(m_ir[28:26]);
        a   = m_reg[m_ir[25:23]];
        b   = m_reg[m_ir[22:20]];
        nxt = m_pc + 16'd1;
        res = '0;
        case (op)
            T_NOP:  ;
            T_HALT: begin nxt = m_pc; m_halted = 1'b1; end
            T_BEQ:  if (a == b) nxt = m_pc + 16'd1 + m_ir[15:0];
            T_BLT:  if (a < b)  nxt = m_pc + 16'd1 + m_ir[15:0];
            default: begin
                case (op)
                    T_ADD:   res = a + b;
                    T_SUB:   res = a - b;
                    T_AND:   res = a & b;
                    default: res = a | b;
                endcase
                if (seed.exists(addr)) res = seed[addr];
                if (rd != 0) m_reg[rd] = res;
            end
        endcase
        m_pc = nxt;
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = '0;
        ovr_en     = 1'b0;
        @(negedge clk);
        #1;
        check_eq("rst_imem_req", imem_req, 1'b0);
        check_eq("rst_retire", retire, 1'b0);
        check_eq("rst_halted", halted, 1'b0);
        check_eq("rst_pc", pc, '0);
        for (int r = 0; r < 8; r++) begin
            dbg_raddr = 3'(r);
            #1;
            check_eq("rst_reg", dbg_rdata, '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_prog(input int budget, input int rst_addr_in, input int lat_mode);
        int  rst_addr;
        int  rst_cyc;
        int  fetch_addr;
        int  lat;
        int  cnt;
        int  halt_cnt;
        bit  pending;
        bit  spur_ok;
        bit  done;
        rst_addr   = rst_addr_in;
        rst_cyc    = -1;
        fetch_addr = 0;
        cnt        = 0;
        halt_cnt   = 0;
        pending    = 1'b0;
        done       = 1'b0;
        apply_reset();
        model_init();
        while (!done) begin
            dbg_raddr = 3'($urandom_range(0, 7));
            #1;
            check_eq("imem_req", imem_req, cyc == m_req_cyc);
            check_eq("retire", retire, cyc == m_ret_cyc);
            check_eq("halted", halted, m_halted);
            check_eq("pc", pc, m_pc);
            check_eq("dbg_rdata", dbg_rdata, m_reg[dbg_raddr]);

            imem_valid = 1'b0;
            imem_rdata = '0;
            spur_ok    = !pending;
            if (cyc == m_req_cyc) begin
                check_eq("imem_addr", imem_addr, m_pc);
                fetch_addr = int'(m_pc);
                m_ir       = fetch_word(fetch_addr);
                if (lat_fix.exists(fetch_addr)) lat = lat_fix[fetch_addr];
                else if (lat_mode == 0)         lat = $urandom_range(1, 4);
                else                            lat = lat_mode;
                m_ret_cyc = cyc + lat + ret_offset(m_ir[31:29]);
                pending   = 1'b1;
                cnt       = lat;
                ovr_en    = seed.exists(fetch_addr);
                ovr_val   = seed.exists(fetch_addr) ? seed[fetch_addr] : 32'h0;
                if (rst_addr == fetch_addr) begin
                    rst_cyc  = cyc + lat + 2;
                    rst_addr = -1;
                end
            end else if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = m_ir;
                    pending    = 1'b0;
                end
            end
            if (spur_ok && !imem_valid && ($urandom_range(0, 3) == 0)) begin
                imem_valid = 1'b1;
                imem_rdata = $urandom;
            end

            if (cyc == m_ret_cyc) begin
                check_eq("alu_opcode", alu_opcode, m_ir[31:29]);
                model_retire(fetch_addr);
                ovr_en    = 1'b0;
                m_req_cyc = m_halted ? -1 : cyc + 1;
            end

            if (m_halted) begin
                halt_cnt++;
                if (halt_cnt > 20) done = 1'b1;
            end

            if (cyc == rst_cyc) begin
                apply_reset();
                model_init();
                pending = 1'b0;
                rst_cyc = -1;
                continue;
            end

            @(negedge clk);
            cyc++;
            if (!done && cyc > budget) begin
                check_eq("halt_by_budget", halted, 1'b1);
                done = 1'b1;
            end
        end
    endtask

    task automatic read_reg(input int r, output logic [31:0] v);
        dbg_raddr = 3'(r);
        #1;
        v = dbg_rdata;
    endtask

    task automatic clear_prog();
        mem.delete();
        seed.delete();
        lat_fix.delete();
    endtask

    task automatic gen_random();
        logic [2:0]  op;
        logic [31:0] w;
        int          imm;
        clear_prog();
        for (int a = 0; a < 6; a++) begin
            mem[a]  = enc(T_ADD, a + 1, 0, 0, 0);
            seed[a] = $urandom_range(0, 3);
        end
        for (int a = 6; a < 40; a++) begin
            op = 3'($urandom_range(0, 7));
            if (op == T_HALT) op = T_NOP;
            imm = (op == T_BEQ || op == T_BLT) ? $urandom_range(0, 7) : int'($urandom_range(0, 65535));
            w = enc(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), imm);
            w[19:16] = 4'($urandom_range(0, 15));
            mem[a] = w;
        end
        for (int a = 40; a < 64; a++) mem[a] = enc(T_HALT, 0, 0, 0, 0);
    endtask

    logic [31:0] v;

    initial begin
        // Directed program: preloads, ADD with a 4-cycle fetch stall, BEQ/BLT
        // taken and not taken, SUB to r0, then HALT.
        clear_prog();
        mem[0]  = enc(T_ADD, 1, 0, 0, 0);  seed[0] = 32'd5;
        mem[1]  = enc(T_ADD, 2, 0, 0, 0);  seed[1] = 32'd7;
        mem[2]  = enc(T_ADD, 3, 1, 2, 0);  lat_fix[2] = 4;
        mem[3]  = enc(T_ADD, 4, 0, 0, 0);  seed[3] = 32'd9;
        mem[4]  = enc(T_ADD, 5, 0, 0, 0);  seed[4] = 32'd9;
        mem[5]  = enc(T_ADD, 6, 0, 0, 0);  seed[5] = 32'd8;
        mem[6]  = enc(T_ADD, 1, 0, 0, 0);  seed[6] = 32'd1;
        mem[7]  = enc(T_ADD, 2, 0, 0, 0);  seed[7] = 32'd2;
        mem[8]  = enc(T_SUB, 0, 3, 4, 0);
        mem[9]  = enc(T_NOP, 0, 0, 0, 0);
        mem[10] = enc(T_BEQ, 0, 4, 5, 3);
        mem[14] = enc(T_BEQ, 0, 4, 6, 5);
        mem[15] = enc(T_BEQ, 0, 0, 0, 3);
        mem[19] = enc(T_NOP, 0, 0, 0, 0);
        mem[20] = enc(T_BLT, 0, 1, 2, -5);
        mem[16] = enc(T_BEQ, 0, 0, 0, 9);
        mem[26] = enc(T_SUB, 7, 3, 1, 0);
        mem[27] = enc(T_AND, 5, 3, 7, 0);
        mem[28] = enc(T_OR,  6, 3, 2, 0);
        mem[29] = enc(T_BLT, 0, 2, 1, -3);
        mem[30] = enc(T_HALT, 0, 0, 0, 0);
        run_prog(1000, -1, 1);
        read_reg(3, v); check_eq("add_r3", v, 32'd12);
        read_reg(0, v); check_eq("r0_zero", v, 32'd0);
        read_reg(7, v); check_eq("sub_r7", v, 32'd11);
        read_reg(5, v); check_eq("and_r5", v, 32'd8);
        read_reg(6, v); check_eq("or_r6", v, 32'd14);
        check_eq("halt_pc", pc, 32'd30);

        // Negative branch offset wrapping below address zero.
        clear_prog();
        mem[0]     = enc(T_ADD, 1, 0, 0, 0);  seed[0] = 32'd1;
        mem[1]     = enc(T_ADD, 2, 0, 0, 0);  seed[1] = 32'd2;
        mem[2]     = enc(T_BLT, 0, 1, 2, -5);
        mem[65534] = enc(T_HALT, 0, 0, 0, 0);
        run_prog(500, -1, 0);
        check_eq("wrap_pc", pc, 32'h0000_FFFE);

        // Reset while the ADD at address 1 is in EXEC, then rerun from scratch.
        clear_prog();
        mem[0] = enc(T_ADD, 1, 0, 0, 0);  seed[0] = 32'd5;
        mem[1] = enc(T_ADD, 2, 1, 1, 0);
        mem[2] = enc(T_HALT, 0, 0, 0, 0);
        run_prog(500, 1, 0);
        read_reg(2, v); check_eq("post_reset_r2", v, 32'd10);
        check_eq("post_reset_pc", pc, 32'd2);

        for (int k = 0; k < 3; k++) begin
            gen_random();
            run_prog(2000, -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
